dmem_arbiter: RTL

Two-requester arbiter and access sequencer in front of the 64 x 32-bit data memory (6-bit word address; reads captured at posedge when `mem_read` is high; writes committed at negedge when `mem_write` is high). Requester 0 is the pipeline MEM stage and requester 1 is the debug/loader port. The arbiter serializes one transaction at a time, drives the memory control lines from registered state and returns a one-cycle acknowledge with read data. It also generates the MEM-stage stall.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and single-transaction sequencer for the 64 x 32 data memory.
// Build option: DMEM_ARB_FIXED_PRIO_EN gives requester 0 absolute priority instead of round-robin.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [5:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [5:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        arb_busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        cmd_we;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] hold0, hold1;
  logic        any_req;
  logic        win_id;
  logic        resp_rd0, resp_rd1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
  logic        last_grant;
`endif

  assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win_id = ~m0_req;
`else
  // On a tie the requester that did not win last time gets the slot.
  assign win_id = (m0_req & m1_req) ? ~last_grant : ~m0_req;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_address    = cmd_addr;
    mem_write_data = cmd_wdata;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    m0_ack         = 1'b0;
    m1_ack         = 1'b0;
    resp_rd0       = 1'b0;
    resp_rd1       = 1'b0;
    if (state == ACCESS) begin
      mem_read  = ~cmd_we;
      mem_write = cmd_we;
    end
    if (state == RESP) begin
      m0_ack   = ~grant_id;
      m1_ack   = grant_id;
      resp_rd0 = ~grant_id & ~cmd_we;
      resp_rd1 = grant_id & ~cmd_we;
    end
  end

  // Read data is passed straight through in the response cycle, then held.
  assign m0_rdata = resp_rd0 ? mem_read_data : hold0;
  assign m1_rdata = resp_rd1 ? mem_read_data : hold1;
  assign m0_stall = m0_req & ~m0_ack;
  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      grant_id  <= 1'b0;
      hold0     <= '0;
      hold1     <= '0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        cmd_we    <= win_id ? m1_we    : m0_we;
        cmd_addr  <= win_id ? m1_addr  : m0_addr;
        cmd_wdata <= win_id ? m1_wdata : m0_wdata;
        grant_id  <= win_id;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
        last_grant <= win_id;
`endif
      end
      if (resp_rd0) hold0 <= mem_read_data;
      if (resp_rd1) hold1 <= mem_read_data;
    end
  end

endmodule
